sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0: 0 = first serial bit lands in dout[0]; 1 = first serial bit lands in dout[WIDTH-1].
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  1  serial data bit, sampled only when din_valid=1.
REQ-006 din_valid  input  1  bit strobe; may deassert between bits (gaps allowed).
REQ-007 dout  output  WIDTH  parallel word held in the output buffer.
REQ-008 dout_valid  output  1  output buffer holds an unconsumed word.
REQ-009 dout_ready  input  1  consumer accepts; transfer occurs when dout_valid and dout_ready are both 1.
REQ-010 busy  output  1  a word is partially shifted in (bit counter nonzero).
REQ-011 overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 clr_err  input  1  clears overrun (and parity_err sticky).
REQ-013 parity_err  output  1  parity mismatch on the word currently in dout (see Configuration).

Function
REQ-014 Shift register and bit counter advance only on cycles with din_valid=1; din is ignored otherwise.
REQ-015 FSM states: IDLE (count 0), SHIFT (1..WIDTH-1 bits held), PAR (data complete, awaiting parity bit; present only with PAR_CHK_EN).
REQ-016 IDLE->SHIFT on first valid bit; SHIFT->IDLE (or ->PAR) on the WIDTH-th valid bit; PAR->IDLE on the next valid bit.
REQ-017 Word completes on the cycle of its final valid bit (last data bit, or parity bit if enabled); dout/dout_valid update on the following rising edge (latency 1 cycle).
REQ-018 Completion with output buffer empty, or full with dout_ready=1 in the same cycle: load new word, dout_valid=1, no overrun.
REQ-019 Completion with buffer full and dout_ready=0: new word dropped, dout unchanged, overrun set to 1.
REQ-020 Handshake with no completion in the same cycle: dout_valid clears on the next edge; dout holds its last value.
REQ-021 Back-to-back words with no gaps are sustained; no idle cycle is required between words.
REQ-022 clr_err and a new overrun event in the same cycle: overrun stays 1 (set wins).
REQ-023 Bit counter width is $clog2(WIDTH+1); the counter never exceeds WIDTH and wraps to 0 at completion.

Reset
REQ-024 rst=1 at a clock edge: FSM=IDLE, counter=0, shift register=0, dout=0, dout_valid=0, busy=0, overrun=0, parity_err=0.
REQ-025 Reset mid-word discards partial bits; the next valid bit after reset is bit 0 of a fresh word.
REQ-026 rst has priority over din_valid, dout_ready and clr_err in the same cycle.

Configuration
REQ-027 Macro SIPO_DESER_PAR_CHK_EN defined: one even-parity bit follows each WIDTH-bit word; PAR state exists; parity_err is loaded with the word (1 = XOR of data bits and parity bit is 1) and clears on handshake or clr_err.
REQ-028 Macro undefined: no parity bit, no PAR state, parity_err tied 0.

Structure
REQ-029 Package sipo_pkg holds the FSM state enum (IDLE, SHIFT, PAR) and a parity-reduction function.
REQ-030 One sub-module, sipo_outbuf: single-entry valid/ready holding register with overrun detection; the top module owns the FSM, counter and shift register.

Verification
REQ-031 WIDTH=8, MSB_FIRST=0, bits 1,0,1,0,0,1,0,1 -> dout=0xA5, dout_valid=1 one cycle after the 8th bit.
REQ-032 MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 -> dout=0xA5; same stream with random din_valid gaps -> identical result.
REQ-033 dout_ready=0, send 0x3C then 0xC3 -> dout stays 0x3C, overrun=1; clr_err pulse -> overrun=0.
REQ-034 3 bits shifted, then rst, then 0x5A -> dout=0x5A, busy=0 after completion, no overrun.
REQ-035 PAR_CHK_EN: 0xA5 followed by parity bit 0 -> parity_err=0; same word with parity bit 1 -> parity_err=1.
REQ-036 Continuous stream 0x01, 0x02, 0x03 with dout_ready=1 -> three handshakes, no overrun, no dropped words.

Source files
------------

// File: rtl/sipo_pkg.sv
// sipo_pkg -- shared types and helpers for the serial-to-parallel deserializer.
//   state_t  : bit-collection FSM states (PAR used only when
//              SIPO_DESER_PAR_CHK_EN is defined)
//   parity32 : XOR reduction of a zero-extended word (even-parity check)
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    // Zero-extension does not change the XOR, so one 32-bit helper serves
    // every legal WIDTH.
    function automatic logic parity32(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sipo_outbuf.sv
// sipo_outbuf -- single-entry valid/ready holding register with overrun flag.
//   clk, rst      : clock, synchronous active-high reset
//   load          : a completed word is offered this cycle
//   load_data     : the completed word
//   load_perr     : parity-error status travelling with the word
//   dout_ready    : consumer accepts when dout_valid is also 1
//   clr_err       : clears the sticky overrun and parity_err flags
//   dout          : held word
//   dout_valid    : buffer holds an unconsumed word
//   overrun       : sticky, a completed word was dropped
//   parity_err    : parity status of the word currently in dout
module sipo_outbuf
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_perr,
    input  logic             dout_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun,
    output logic             parity_err
);

    logic hs;
    logic accept;
    logic drop;

    assign hs     = dout_valid & dout_ready;
    // A full buffer being drained this cycle can take the new word at once,
    // which is what lets back-to-back words stream without bubbles.
    assign accept = load & (~dout_valid | dout_ready);
    assign drop   = load & dout_valid & ~dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (accept) begin
                dout       <= load_data;
                dout_valid <= 1'b1;
                parity_err <= load_perr;
            end else begin
                if (hs)
                    dout_valid <= 1'b0;
                if (hs || clr_err)
                    parity_err <= 1'b0;
            end
            // A drop in the same cycle as clr_err keeps the flag set.
            overrun <= drop | (overrun & ~clr_err);
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser -- serial-in, parallel-out deserializer with one-word output
// buffer.
//   Optional feature macro: SIPO_DESER_PAR_CHK_EN (one even-parity bit after
//   each word, checked into parity_err). Undefined: parity_err is always 0.
//   clk, rst      : clock, synchronous active-high reset
//   din, din_valid: serial bit and its strobe (gaps allowed)
//   dout          : parallel word in the output buffer
//   dout_valid    : buffer holds an unconsumed word
//   dout_ready    : consumer handshake
//   busy          : a word is partially shifted in
//   overrun       : sticky, a completed word was dropped
//   clr_err       : clears overrun / parity_err
//   parity_err    : parity mismatch on the word in dout
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_err,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SIPO_DESER_PAR_CHK_EN
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
`endif

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n, sr_shift, word;
    logic             done;
    logic             perr_in;

    // LSB-first shifts in from the top so the first bit ends in bit 0;
    // MSB-first shifts in from the bottom so it ends in bit WIDTH-1.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign sr_shift = {sr[WIDTH-2:0], din};
        end else begin : g_lsb
            assign sr_shift = {din, sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        done    = 1'b0;
        word    = sr_shift;
        perr_in = 1'b0;
        if (din_valid) begin
            case (state)
                IDLE, SHIFT: begin
                    sr_n = sr_shift;
                    if (cnt == LAST) begin
`ifdef SIPO_DESER_PAR_CHK_EN
                        // Data complete; counter parks at WIDTH so busy
                        // stays high until the parity bit arrives.
                        state_n = PAR;
                        cnt_n   = FULL;
`else
                        state_n = IDLE;
                        cnt_n   = '0;
                        done    = 1'b1;
`endif
                    end else begin
                        state_n = SHIFT;
                        cnt_n   = cnt + CW'(1);
                    end
                end
`ifdef SIPO_DESER_PAR_CHK_EN
                PAR: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done    = 1'b1;
                    word    = sr;
                    perr_in = parity32(32'(sr)) ^ din;
                end
`endif
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign busy = (cnt != '0);

    // Without the parity feature load_perr is constant 0, so the buffer's
    // parity register reduces to a constant 0.
    sipo_outbuf #(.WIDTH(WIDTH)) u_outbuf (
        .clk        (clk),
        .rst        (rst),
        .load       (done),
        .load_data  (word),
        .load_perr  (perr_in),
        .dout_ready (dout_ready),
        .clr_err    (clr_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst, din, din_valid, dout_ready, clr_err;
    logic [7:0] dout0, dout1;
    logic       dv0, dv1, busy0, busy1, ov0, ov1, pe0, pe1;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SIPO_DESER_PAR_CHK_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready),
        .busy(busy0), .overrun(ov0), .clr_err(clr_err), .parity_err(pe0)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready),
        .busy(busy1), .overrun(ov1), .clr_err(clr_err), .parity_err(pe1)
    );

    typedef struct {
        logic [7:0] word;
        int         gap_max;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;

    vec_t vt[6];

    // Handshake monitor for the streaming test, sampled mid-cycle.
    logic       mon_en = 1'b0;
    logic [7:0] hsq[$];
    always @(negedge clk)
        if (mon_en && dv0 && dout_ready)
            hsq.push_back(dout0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Sends w LSB first (plus pbit when parity is built in). Random idle
    // cycles with junk din precede every bit after the first. rdy_last
    // raises dout_ready only for the cycle of the final bit.
    task automatic send_bits(input logic [7:0] w, input int gap_max,
                             input logic pbit, input bit rdy_last);
        logic [8:0] s;
        s = {pbit, w};
        for (int i = 0; i < NB; i++) begin
            if (i > 0 && gap_max > 0) begin
                din_valid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) begin
                    din = 1'($urandom);
                    tick();
                end
            end
            din       = s[i];
            din_valid = 1'b1;
            if (rdy_last && i == NB - 1)
                dout_ready = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        if (rdy_last)
            dout_ready = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap_max);
        send_bits(w, gap_max, ^w, 1'b0);
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0; clr_err = 1'b0;
        vt[0] = '{8'hA5, 0, 8'hA5, 8'hA5};
        vt[1] = '{8'hA5, 2, 8'hA5, 8'hA5};
        vt[2] = '{8'h01, 1, 8'h01, 8'h80};
        vt[3] = '{8'h0F, 0, 8'h0F, 8'hF0};
        vt[4] = '{8'h12, 2, 8'h12, 8'h48};
        vt[5] = '{8'h5A, 1, 8'h5A, 8'h5A};

        // Reset state
        tick(); tick();
        chk("rst_dout0", dout0, 0);
        chk("rst_dout1", dout1, 0);
        chk("rst_dv0", dv0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_ov0", ov0, 0);
        chk("rst_pe0", pe0, 0);
        rst = 1'b0;
        tick();

        // Table-driven words, both bit orders, with and without gaps
        foreach (vt[k]) begin
            send_word(vt[k].word, vt[k].gap_max);
            chk($sformatf("v%0d_dout0", k), dout0, vt[k].exp0);
            chk($sformatf("v%0d_dout1", k), dout1, vt[k].exp1);
            chk($sformatf("v%0d_dv0", k), dv0, 1);
            chk($sformatf("v%0d_dv1", k), dv1, 1);
            chk($sformatf("v%0d_busy0", k), busy0, 0);
            chk($sformatf("v%0d_ov0", k), ov0, 0);
            chk($sformatf("v%0d_pe0", k), pe0, 0);
            drain();
            chk($sformatf("v%0d_dv0_after_hs", k), dv0, 0);
            chk($sformatf("v%0d_dout0_hold", k), dout0, vt[k].exp0);
        end

        // Partial word, then reset mid-word (reset beats din_valid)
        din_valid = 1'b1;
        din = 1'b1; tick();
        din = 1'b1; tick();
        din = 1'b0; tick();
        chk("partial_busy", busy0, 1);
        rst = 1'b1; din = 1'b1; tick();
        rst = 1'b0; din_valid = 1'b0;
        chk("midrst_busy", busy0, 0);
        chk("midrst_dout0", dout0, 0);
        send_word(8'h5A, 0);
        chk("after_rst_dout0", dout0, 8'h5A);
        chk("after_rst_dv0", dv0, 1);
        chk("after_rst_busy", busy0, 0);
        chk("after_rst_ov0", ov0, 0);
        drain();

        // Overrun: full buffer, consumer stalled
        send_word(8'h3C, 0);
        send_word(8'hC3, 0);
        chk("ovr_dout0", dout0, 8'h3C);
        chk("ovr_dv0", dv0, 1);
        chk("ovr_flag", ov0, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("ovr_clr", ov0, 0);

        // Drop coinciding with clr_err: set wins
        clr_err = 1'b1;
        send_word(8'h99, 1);
        clr_err = 1'b0;
        chk("setwins_ov0", ov0, 1);
        chk("setwins_dout0", dout0, 8'h3C);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("setwins_clr", ov0, 0);

        // Full buffer drained in the very cycle a new word completes
        send_bits(8'h66, 0, ^8'h66, 1'b1);
        chk("rdy_same_dout0", dout0, 8'h66);
        chk("rdy_same_dv0", dv0, 1);
        chk("rdy_same_ov0", ov0, 0);
        drain();
        chk("rdy_same_drained", dv0, 0);

        // Back-to-back stream with the consumer always ready
        hsq.delete();
        mon_en = 1'b1;
        dout_ready = 1'b1;
        send_word(8'h01, 0);
        send_word(8'h02, 0);
        send_word(8'h03, 0);
        tick(); tick();
        mon_en = 1'b0;
        dout_ready = 1'b0;
        chk("stream_hs_count", hsq.size(), 3);
        if (hsq.size() == 3) begin
            chk("stream_w0", hsq[0], 8'h01);
            chk("stream_w1", hsq[1], 8'h02);
            chk("stream_w2", hsq[2], 8'h03);
        end
        chk("stream_ov0", ov0, 0);
        chk("stream_dv0", dv0, 0);

`ifdef SIPO_DESER_PAR_CHK_EN
        // Parity: good bit, bad bit, cleared by clr_err and by handshake
        send_bits(8'hA5, 0, 1'b0, 1'b0);
        chk("par_good", pe0, 0);
        drain();
        send_bits(8'hA5, 0, 1'b1, 1'b0);
        chk("par_bad", pe0, 1);
        chk("par_bad_dout0", dout0, 8'hA5);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("par_clr", pe0, 0);
        drain();
        send_bits(8'h01, 0, 1'b0, 1'b0);
        chk("par_bad2", pe0, 1);
        drain();
        chk("par_hs_clr", pe0, 0);
`else
        send_bits(8'h07, 1, 1'b1, 1'b0);
        chk("nopar_pe0", pe0, 0);
        chk("nopar_dout0", dout0, 8'h07);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
